// File: rtl/fcmp_share_arbiter.sv
// Round-robin arbiter sharing one float magnitude comparator between NUM_REQ requesters.
// Each accepted request runs IDLE -> CMP -> RESP and returns a one-hot, single-cycle response.
module fcmp_share_arbiter #(
    parameter int NUM_REQ = 2,
    parameter int IDW     = 1
) (
    input  logic                    CLK,
    input  logic                    RESET,
    input  logic [NUM_REQ-1:0]      req_valid,
    output logic [NUM_REQ-1:0]      req_ready,
    input  logic [3*NUM_REQ-1:0]    req_op,
    input  logic [32*NUM_REQ-1:0]   req_a,
    input  logic [32*NUM_REQ-1:0]   req_b,
    output logic [NUM_REQ-1:0]      resp_valid,
    output logic [31:0]             resp_data,
    output logic                    busy
);

    // state | meaning
    // IDLE  | searching for a winner from rr_ptr, req_ready asserted combinationally
    // CMP   | latched operands go through the comparator, result registered
    // RESP  | one-cycle resp_valid to the owner is launched, then back to IDLE
    typedef enum logic [1:0] {IDLE = 2'd0, CMP = 2'd1, RESP = 2'd2} state_t;

    localparam logic [IDW:0] NREQ = (IDW+1)'(NUM_REQ);

    state_t         state;
    logic [IDW-1:0] rr_ptr;
    logic [IDW-1:0] owner;
    logic [IDW-1:0] win_idx;
    logic [IDW-1:0] next_ptr;
    logic [IDW:0]   scan_idx;
    logic [IDW:0]   inc_idx;
    logic           win_found;
    logic [31:0]    a_q, b_q, sel_a, sel_b;
    logic [2:0]     op_q, sel_op;
    logic [1:0]     cmp;
    logic [31:0]    result;

    // 00 equal, 01 a>b, 10 a<b; sign-magnitude ordering so -0 < +0
    function automatic logic [1:0] fcmp(input logic [31:0] a, input logic [31:0] b);
        if (a == b)
            return 2'b00;
        else if (a[31] != b[31])
            return a[31] ? 2'b10 : 2'b01;
        else if (!a[31])
            return (a[30:0] > b[30:0]) ? 2'b01 : 2'b10;
        else
            return (a[30:0] > b[30:0]) ? 2'b10 : 2'b01;
    endfunction

    always_comb begin
        win_found = 1'b0;
        win_idx   = '0;
        scan_idx  = '0;
        for (int k = 0; k < NUM_REQ; k++) begin
            scan_idx = {1'b0, rr_ptr} + (IDW+1)'(k);
            if (scan_idx >= NREQ)
                scan_idx = scan_idx - NREQ;
            if (!win_found && req_valid[scan_idx[IDW-1:0]]) begin
                win_found = 1'b1;
                win_idx   = scan_idx[IDW-1:0];
            end
        end
    end

    always_comb begin
        inc_idx  = {1'b0, win_idx} + (IDW+1)'(1);
        next_ptr = (inc_idx >= NREQ) ? '0 : inc_idx[IDW-1:0];
    end

    always_comb begin
        sel_a  = '0;
        sel_b  = '0;
        sel_op = '0;
        for (int i = 0; i < NUM_REQ; i++) begin
            if (win_idx == IDW'(i)) begin
                sel_a  = req_a[32*i +: 32];
                sel_b  = req_b[32*i +: 32];
                sel_op = req_op[3*i +: 3];
            end
        end
    end

    always_comb begin
        req_ready = '0;
        if (state == IDLE && !RESET && win_found)
            req_ready[win_idx] = 1'b1;
    end

    always_comb begin
        cmp = fcmp(a_q, b_q);
        case (op_q)
            3'b000:  result = {31'b0, cmp == 2'b00};
            3'b001:  result = {31'b0, cmp == 2'b10};
            3'b010:  result = {31'b0, cmp != 2'b01};
            3'b011:  result = (cmp == 2'b01) ? b_q : a_q;
            3'b100:  result = (cmp == 2'b01) ? a_q : b_q;
            default: result = '0;
        endcase
    end

    assign busy = (state == CMP) || (state == RESP);

    always_ff @(posedge CLK) begin
        if (RESET) begin
            state      <= IDLE;
            rr_ptr     <= '0;
            owner      <= '0;
            a_q        <= '0;
            b_q        <= '0;
            op_q       <= '0;
            resp_valid <= '0;
            resp_data  <= '0;
        end else begin
            resp_valid <= '0;
            case (state)
                IDLE: begin
                    if (win_found) begin
                        a_q    <= sel_a;
                        b_q    <= sel_b;
                        op_q   <= sel_op;
                        owner  <= win_idx;
                        rr_ptr <= next_ptr;
                        state  <= CMP;
                    end
                end
                CMP: begin
                    resp_data <= result;
                    state     <= RESP;
                end
                RESP: begin
                    resp_valid[owner] <= 1'b1;
                    state             <= IDLE;
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_fcmp_share_arbiter.sv
// Bench for fcmp_share_arbiter: per-cycle check against a transaction-level model
// plus directed transactions with literal expected results.
module tb_fcmp_share_arbiter;

    localparam int N = 2;

    logic              CLK = 1'b0;
    logic              RESET;
    logic [N-1:0]      req_valid;
    logic [N-1:0]      req_ready;
    logic [3*N-1:0]    req_op;
    logic [32*N-1:0]   req_a;
    logic [32*N-1:0]   req_b;
    logic [N-1:0]      resp_valid;
    logic [31:0]       resp_data;
    logic              busy;

    int n_checks = 0;
    int n_fail   = 0;
    bit chk_en   = 1'b0;

    fcmp_share_arbiter #(.NUM_REQ(N), .IDW(1)) dut (
        .CLK        (CLK),
        .RESET      (RESET),
        .req_valid  (req_valid),
        .req_ready  (req_ready),
        .req_op     (req_op),
        .req_a      (req_a),
        .req_b      (req_b),
        .resp_valid (resp_valid),
        .resp_data  (resp_data),
        .busy       (busy)
    );

    always #5 CLK = ~CLK;

    task automatic check32(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%08h expected 0x%08h at %0t", name, act, exp, $time);
        end
    endtask

    // ---------------- model ----------------
    // Floats mapped onto a monotonic signed integer key; -0 sits just below +0.
    function automatic longint fkey(input logic [31:0] x);
        if (x[31]) return -longint'(x[30:0]) - 1;
        return longint'(x[30:0]);
    endfunction

    function automatic logic [31:0] ref_op(input logic [2:0] op, input logic [31:0] a, input logic [31:0] b);
        longint ka, kb;
        ka = fkey(a);
        kb = fkey(b);
        case (op)
            3'd0:    return (ka == kb) ? 32'd1 : 32'd0;
            3'd1:    return (ka <  kb) ? 32'd1 : 32'd0;
            3'd2:    return (ka <= kb) ? 32'd1 : 32'd0;
            3'd3:    return (ka >  kb) ? b : a;
            3'd4:    return (ka >  kb) ? a : b;
            default: return 32'd0;
        endcase
    endfunction

    function automatic int pick(input logic [N-1:0] v, input int rr);
        logic [N-1:0] sh;
        for (int k = 0; k < N; k++) begin
            sh = v >> ((rr + k) % N);
            if (sh[0]) return (rr + k) % N;
        end
        return -1;
    endfunction

    int           m_cnt;     // cycles since accept, 0 = nothing outstanding
    int           m_rr;
    int           m_owner;
    logic [31:0]  m_res;
    logic [31:0]  m_rd;
    logic [N-1:0] m_rv;

    always @(posedge CLK) begin
        int w;
        if (RESET) begin
            m_cnt = 0; m_rr = 0; m_owner = 0; m_res = '0; m_rd = '0; m_rv = '0;
        end else begin
            m_rv = '0;
            if (m_cnt == 0) begin
                w = pick(req_valid, m_rr);
                if (w >= 0) begin
                    m_owner = w;
                    m_res   = ref_op(req_op[3*w +: 3], req_a[32*w +: 32], req_b[32*w +: 32]);
                    m_rr    = (w + 1) % N;
                    m_cnt   = 1;
                end
            end else if (m_cnt == 1) begin
                m_rd  = m_res;
                m_cnt = 2;
            end else begin
                m_rv  = N'(1) << m_owner;
                m_cnt = 0;
            end
        end
    end

    function automatic logic [N-1:0] exp_ready();
        int w;
        if (m_cnt != 0 || RESET) return '0;
        w = pick(req_valid, m_rr);
        if (w < 0) return '0;
        return N'(1) << w;
    endfunction

    always @(negedge CLK) begin
        if (chk_en) begin
            check32("req_ready",  32'(req_ready),  32'(exp_ready()));
            check32("resp_valid", 32'(resp_valid), 32'(m_rv));
            check32("busy",       {31'b0, busy},   {31'b0, m_cnt != 0});
            if (m_rv != 0)
                check32("resp_data", resp_data, m_rd);
        end
    end

    // ---------------- stimulus ----------------
    task automatic do_op(input int idx, input logic [2:0] op, input logic [31:0] a, input logic [31:0] b,
                         output logic [N-1:0] rdy, output int wait_n, output int lat,
                         output logic [31:0] d, output logic [N-1:0] rv);
        @(posedge CLK); #1;
        req_op[3*idx +: 3]  = op;
        req_a[32*idx +: 32] = a;
        req_b[32*idx +: 32] = b;
        req_valid[idx]      = 1'b1;
        wait_n = 0;
        do begin
            @(negedge CLK);
            wait_n++;
        end while (req_ready == 0 && wait_n < 20);
        check32("grant_timeout", {31'b0, req_ready != 0}, 32'd1);
        rdy = req_ready;
        @(posedge CLK); #1;
        req_valid[idx] = 1'b0;
        lat = 0;
        do begin
            @(negedge CLK);
            lat++;
        end while (resp_valid == 0 && lat < 10);
        d  = resp_data;
        rv = resp_valid;
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [N-1:0] rdy, rv;
        logic [31:0]  d;
        int           wn, lat, pulses;
        int           grants[$];
        logic [31:0]  resps[$];

        RESET = 1'b1; req_valid = '0; req_op = '0; req_a = '0; req_b = '0;
        repeat (2) @(posedge CLK);
        #1 chk_en = 1'b1;
        @(negedge CLK);
        check32("rst_ready", 32'(req_ready), 32'd0);
        check32("rst_rvalid", 32'(resp_valid), 32'd0);
        check32("rst_rdata", resp_data, 32'd0);
        check32("rst_busy", {31'b0, busy}, 32'd0);
        @(posedge CLK); #1 RESET = 1'b0;

        // FLT(-1.0, 1.0)
        do_op(0, 3'b001, 32'hBF800000, 32'h3F800000, rdy, wn, lat, d, rv);
        check32("t1_ready", 32'(rdy), 32'h1);
        check32("t1_latency", lat, 32'd3);
        check32("t1_rvalid", 32'(rv), 32'h1);
        check32("t1_data", d, 32'h00000001);

        // both requesters continuously valid, from rr_ptr = 0
        @(posedge CLK); #1 RESET = 1'b1;
        @(posedge CLK); #1 RESET = 1'b0;
        req_op = {3'b011, 3'b100};
        req_a  = {32'hC0400000, 32'h40000000};
        req_b  = {32'hC0000000, 32'h40400000};
        req_valid = 2'b11;
        for (int c = 0; c < 14; c++) begin
            @(negedge CLK);
            if (req_ready != 0) grants.push_back(req_ready[1] ? 1 : 0);
            if (resp_valid != 0) resps.push_back(resp_data);
            if (grants.size() == 3 && req_valid != 0) begin
                @(posedge CLK); #1 req_valid = '0;
            end
        end
        check32("t2_ngrants", grants.size(), 32'd3);
        check32("t2_nresps", resps.size(), 32'd3);
        if (grants.size() == 3 && resps.size() == 3) begin
            check32("t2_grant0", grants[0], 32'd0);
            check32("t2_grant1", grants[1], 32'd1);
            check32("t2_grant2", grants[2], 32'd0);
            check32("t2_resp0", resps[0], 32'h40400000);
            check32("t2_resp1", resps[1], 32'hC0400000);
            check32("t2_resp2", resps[2], 32'h40400000);
        end

        // equality and signed-zero cases
        do_op(0, 3'b000, 32'h3F800000, 32'h3F800000, rdy, wn, lat, d, rv);
        check32("feq_equal", d, 32'd1);
        do_op(1, 3'b000, 32'h00000000, 32'h80000000, rdy, wn, lat, d, rv);
        check32("feq_pm_zero", d, 32'd0);
        do_op(0, 3'b010, 32'h40A00000, 32'h40A00000, rdy, wn, lat, d, rv);
        check32("fle_equal", d, 32'd1);
        do_op(1, 3'b001, 32'h80000000, 32'h00000000, rdy, wn, lat, d, rv);
        check32("flt_mz_pz", d, 32'd1);
        do_op(0, 3'b011, 32'h3F800000, 32'hBF800000, rdy, wn, lat, d, rv);
        check32("fmin_mixed", d, 32'hBF800000);

        // reserved op still responds to its owner
        do_op(1, 3'b110, 32'h12345678, 32'h9ABCDEF0, rdy, wn, lat, d, rv);
        check32("op110_data", d, 32'd0);
        check32("op110_rvalid", 32'(rv), 32'h2);

        // reset while in CMP abandons the transaction
        @(posedge CLK); #1;
        req_op[2:0] = 3'b000; req_a[31:0] = 32'h1; req_b[31:0] = 32'h1;
        req_valid = 2'b01;
        @(negedge CLK);
        check32("t5_ready", 32'(req_ready), 32'h1);
        @(posedge CLK); #1;
        req_valid = '0;
        RESET = 1'b1;
        @(posedge CLK); #1;
        @(negedge CLK);
        check32("t5_busy", {31'b0, busy}, 32'd0);
        check32("t5_rvalid", 32'(resp_valid), 32'd0);
        @(posedge CLK); #1 RESET = 1'b0;
        pulses = 0;
        for (int c = 0; c < 5; c++) begin
            @(negedge CLK);
            if (resp_valid != 0) pulses++;
        end
        check32("t5_no_resp", pulses, 32'd0);

        // rr_ptr is back at 0: with both valid, requester 0 wins
        @(posedge CLK); #1 req_valid = 2'b11;
        @(negedge CLK);
        check32("t5_rr_zero", 32'(req_ready), 32'h1);
        #1 req_valid = '0;

        // only requester 1 valid while rr_ptr = 0
        do_op(1, 3'b100, 32'h3F800000, 32'h40000000, rdy, wn, lat, d, rv);
        check32("t6_ready", 32'(rdy), 32'h2);
        check32("t6_wait", wn, 32'd1);
        check32("t6_data", d, 32'h40000000);
        check32("t6_rvalid", 32'(rv), 32'h2);

        repeat (3) @(negedge CLK);
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
